// File: rtl/scope_capture_ctrl.sv
// Trigger and capture sequencer: decimates the ADC sample stream, finds a level
// crossing (or forces one in auto mode) and fills one display line buffer.
module scope_capture_ctrl #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned DEPTH        = 640,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              trig_mode,
    input  logic [3:0]        decim,
    input  logic              frame_end,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        state,
    output logic              triggered,
    output logic              auto_fired,
    output logic              capture_done
);

    localparam int unsigned       TO_W      = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    state_t            st;
    logic [3:0]        dec_cnt;
    logic [TO_W-1:0]   tcnt;
    logic [DATA_W-1:0] prev;

    logic              accept_c;
    logic              rise_c;
    logic              fall_c;
    logic              hit_c;
    logic              force_c;
    logic [TO_W-1:0]   tcnt_inc_c;
    logic [ADDR_W-1:0] addr_inc_c;

    assign state = st;

    // A sample counts only when the decimation counter has run down to zero.
    assign accept_c   = sample_valid && (st != ST_IDLE) && (dec_cnt == 4'd0);
    assign rise_c     = (prev < trig_level) && (sample_data >= trig_level);
    assign fall_c     = (prev >= trig_level) && (sample_data < trig_level);
    assign hit_c      = trig_edge ? fall_c : rise_c;
    assign tcnt_inc_c = tcnt + TO_W'(1);
    assign force_c    = trig_mode && (tcnt_inc_c == TO_LAST);
    assign addr_inc_c = wr_addr + ADDR_W'(1);

    // Decimation counter; decim is only looked at on reload.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_cnt <= 4'd0;
        end else if (st == ST_IDLE) begin
            dec_cnt <= 4'd0;
        end else if (sample_valid) begin
            dec_cnt <= (dec_cnt == 4'd0) ? decim : dec_cnt - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st           <= ST_IDLE;
            tcnt         <= '0;
            prev         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            triggered    <= 1'b0;
            auto_fired   <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            capture_done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (run) begin
                        st         <= ST_ARM;
                        triggered  <= 1'b0;
                        auto_fired <= 1'b0;
                        tcnt       <= '0;
                    end
                end
                ST_ARM: begin
                    triggered  <= 1'b0;
                    auto_fired <= 1'b0;
                    tcnt       <= '0;
                    if (!run) begin
                        st <= ST_IDLE;
                    end else if (accept_c) begin
                        prev <= sample_data;
                        st   <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (!run) begin
                        st <= ST_IDLE;
                    end else if (accept_c) begin
                        if (hit_c || force_c) begin
                            triggered  <= 1'b1;
                            auto_fired <= !hit_c;
                            wr_en      <= 1'b1;
                            wr_addr    <= '0;
                            wr_data    <= sample_data;
                            if (LAST_ADDR == '0) begin
                                capture_done <= 1'b1;
                                st           <= ST_HOLD;
                            end else begin
                                st <= ST_CAPTURE;
                            end
                        end else begin
                            prev <= sample_data;
                            if (trig_mode) begin
                                tcnt <= tcnt_inc_c;
                            end
                        end
                    end
                end
                ST_CAPTURE: begin
                    // run is ignored here so a started capture always completes.
                    if (accept_c) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_inc_c;
                        wr_data <= sample_data;
                        if (addr_inc_c == LAST_ADDR) begin
                            capture_done <= 1'b1;
                            st           <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // capture_done marks the final-write cycle, whose frame_end is too early.
                    if (frame_end && !capture_done) begin
                        if (run) begin
                            st         <= ST_ARM;
                            triggered  <= 1'b0;
                            auto_fired <= 1'b0;
                            tcnt       <= '0;
                        end else begin
                            st <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl: directed stimulus, a cycle model built from the
// trigger/capture rules, and hand-computed expectations per scenario.
module tb_scope_capture_ctrl;

    localparam int DW    = 12;
    localparam int AW    = 10;
    localparam int DEPTH = 640;
    localparam int ATO   = 4096;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_edge = 1'b0;
    logic          trig_mode = 1'b0;
    logic [3:0]    decim = '0;
    logic          frame_end = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [2:0]    state;
    logic          triggered;
    logic          auto_fired;
    logic          capture_done;

    scope_capture_ctrl #(
        .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .AUTO_TIMEOUT(ATO)
    ) dut (
        .clock(clock), .reset(reset), .run(run),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .trig_level(trig_level), .trig_edge(trig_edge), .trig_mode(trig_mode),
        .decim(decim), .frame_end(frame_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .state(state),
        .triggered(triggered), .auto_fired(auto_fired), .capture_done(capture_done)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase number, samples to skip, writes done so far, samples waited.
    int m_state = 0, m_skip = 0, m_prev = 0, m_nwait = 0, m_written = 0;
    int m_addr = 0, m_data = 0;
    bit m_wr = 0, m_done = 0, m_trig = 0, m_auto = 0;
    bit take, hit, forced, was_done, above_now, above_before;

    task automatic model_write(input int s);
        m_wr   = 1'b1;
        m_addr = m_written;
        m_data = s;
        m_written++;
        if (m_written == DEPTH) begin
            m_done  = 1'b1;
            m_state = 4;
        end else begin
            m_state = 3;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                m_state = 0; m_skip = 0; m_prev = 0; m_nwait = 0; m_written = 0;
                m_addr = 0; m_data = 0; m_wr = 0; m_done = 0; m_trig = 0; m_auto = 0;
            end else begin
                was_done = m_done;
                m_wr = 0;
                m_done = 0;
                take = (m_state != 0) && sample_valid && (m_skip == 0);
                if (m_state == 0) m_skip = 0;
                else if (sample_valid) m_skip = (m_skip == 0) ? int'(decim) : m_skip - 1;
                if (m_state == 0) begin
                    if (run) begin m_state = 1; m_trig = 0; m_auto = 0; end
                end else if (m_state == 1) begin
                    m_trig = 0; m_auto = 0; m_nwait = 0; m_written = 0;
                    if (!run) m_state = 0;
                    else if (take) begin m_prev = int'(sample_data); m_state = 2; end
                end else if (m_state == 2) begin
                    if (!run) m_state = 0;
                    else if (take) begin
                        if (trig_mode) m_nwait++;
                        above_now    = int'(sample_data) >= int'(trig_level);
                        above_before = m_prev >= int'(trig_level);
                        hit    = (above_now != above_before) && (above_now == !trig_edge);
                        forced = !hit && trig_mode && (m_nwait == ATO - 1);
                        if (hit || forced) begin
                            m_trig = 1; m_auto = forced;
                            model_write(int'(sample_data));
                        end else begin
                            m_prev = int'(sample_data);
                        end
                    end
                end else if (m_state == 3) begin
                    if (take) model_write(int'(sample_data));
                end else if (m_state == 4) begin
                    if (frame_end && !was_done) begin
                        if (run) begin m_state = 1; m_trig = 0; m_auto = 0; end
                        else m_state = 0;
                    end
                end
            end
        end
    end

    int wa[$];
    int wd[$];
    int wdone[$];

    // Per-cycle compare of every output against the model, plus a write log.
    initial begin
        forever begin
            @(negedge clock);
            check("outputs",
                  64'({state, wr_en, capture_done, triggered, auto_fired, wr_addr, wr_data}),
                  64'({3'(m_state), m_wr, m_done, m_trig, m_auto, AW'(m_addr), DW'(m_data)}));
            if (wr_en === 1'b1) begin
                wa.push_back(int'(wr_addr));
                wd.push_back(int'(wr_data));
                wdone.push_back(int'(capture_done));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic pulse_frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wdone.delete();
    endtask

    function automatic int done_count();
        int n = 0;
        foreach (wdone[i]) n += wdone[i];
        return n;
    endfunction

    initial begin
        int n;
        #1 reset = 1'b0;
        // Reset with random inputs
        repeat (6) begin
            tick();
            run = 1'($urandom); sample_valid = 1'($urandom); sample_data = DW'($urandom);
            trig_level = DW'($urandom); trig_edge = 1'($urandom); trig_mode = 1'($urandom);
            decim = 4'($urandom); frame_end = 1'($urandom);
        end
        tick();
        check("reset_outputs", 64'({state, wr_en, capture_done, triggered, auto_fired, wr_addr, wr_data}), 64'(0));
        sample_valid = 0; frame_end = 0; decim = 0; trig_level = 12'd2048;
        trig_edge = 0; trig_mode = 0; run = 1; reset = 1;
        tick();
        check("release_arm", 64'(state), 64'(1));

        // Rising trigger on an ascending ramp
        clear_log();
        for (int i = 0; i < 768; i++) send(DW'(i * 16), 4);
        check("rise_count", 64'(wa.size()), 64'(640));
        check("rise_first", 64'({wa[0], wd[0]}), 64'({32'd0, 32'd2048}));
        check("rise_last", 64'({wa[639], wd[639]}), 64'({32'd639, 32'd4080}));
        check("rise_done_last", 64'({wdone[639], done_count()}), 64'({32'd1, 32'd1}));
        check("rise_hold", 64'({state, triggered, auto_fired}), 64'({3'd4, 1'b1, 1'b0}));
        pulse_frame();
        check("rearm", 64'({state, triggered}), 64'({3'd1, 1'b0}));

        // Falling trigger with decimation 4
        decim = 3; trig_edge = 1; trig_level = 12'd1000;
        clear_log();
        for (int i = 0; i < 2770; i++) send(DW'(1200 - i), 1);
        check("fall_count", 64'(wa.size()), 64'(640));
        check("fall_first", 64'({wa[0], wd[0]}), 64'({32'd0, 32'd996}));
        check("fall_last", 64'({wa[639], wd[639]}), 64'({32'd639, 32'd2536}));
        n = 0;
        for (int k = 1; k < wd.size(); k++) if (((wd[k-1] - wd[k]) & 4095) == 4) n++;
        check("fall_step4", 64'(n), 64'(639));
        run = 0;
        pulse_frame();
        check("hold_to_idle", 64'({state, triggered}), 64'({3'd0, 1'b1}));

        // Auto mode on a flat input
        decim = 0; trig_edge = 0; trig_level = 12'd2048; trig_mode = 1; run = 1;
        tick();
        clear_log();
        for (int i = 0; i < ATO - 1; i++) send(12'd100, 1);
        check("auto_waiting", 64'({state, 32'(wa.size())}), 64'({3'd2, 32'd0}));
        send(12'd100, 1);
        check("auto_fire", 64'({state, triggered, auto_fired, wr_en}), 64'({3'd3, 1'b1, 1'b1, 1'b1}));
        for (int i = 0; i < DEPTH - 1; i++) send(12'd100, 1);
        tick();
        n = 0;
        foreach (wd[k]) if (wd[k] == 100) n++;
        check("auto_writes", 64'({32'(wa.size()), 32'(n)}), 64'({32'd640, 32'd640}));
        check("auto_hold", 64'({state, auto_fired}), 64'({3'd4, 1'b1}));

        // Normal mode on a flat input never triggers
        trig_mode = 0;
        pulse_frame();
        clear_log();
        for (int i = 0; i < ATO + DEPTH; i++) send(12'd100, 1);
        check("normal_stuck", 64'({state, auto_fired, 32'(wa.size())}), 64'({3'd2, 1'b0, 32'd0}));
        // Crossing sample coincident with run falling: idle, no write
        run = 0;
        send(12'd3000, 1);
        tick();
        check("abort_wait", 64'({state, 32'(wa.size())}), 64'({3'd0, 32'd0}));

        // run drop mid-capture, frame_end on the final write
        run = 1;
        tick();
        clear_log();
        send(12'd0, 2);
        send(12'd3000, 2);
        for (int k = 1; k < DEPTH; k++) begin
            if (k == 300) run = 0;
            if (k == DEPTH - 1) begin
                sample_valid = 1; sample_data = DW'(k * 7);
                tick();
                sample_valid = 0; frame_end = 1;
                tick();
                frame_end = 0;
            end else begin
                send(DW'(k * 7), 2);
            end
        end
        tick();
        check("nabort_hold", 64'({state, 32'(wa.size()), 32'(wa[639])}), 64'({3'd4, 32'd640, 32'd639}));
        pulse_frame();
        check("nabort_idle", 64'(state), 64'(0));

        // Asynchronous reset mid-capture
        run = 1;
        tick();
        send(12'd0, 1);
        send(12'd3000, 1);
        for (int k = 1; k <= 300; k++) send(DW'(k), 1);
        check("pre_reset", 64'({wr_en, wr_addr, state}), 64'({1'b1, 10'd300, 3'd3}));
        reset = 0;
        #1;
        check("async_reset", 64'({state, wr_en, capture_done, triggered, auto_fired, wr_addr, wr_data}), 64'(0));
        tick();
        run = 0; reset = 1;
        tick();
        tick();
        check("post_reset_idle", 64'(state), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
- Trigger and capture sequencer that sits between an ADC channel output (e.g. CH0 of the ADC interface) and the per-channel display line buffer read by the VGA renderer.
- Arms on request, finds a level crossing on the decimated sample stream, writes DEPTH consecutive samples into the buffer, then freezes the buffer until the display finishes a frame.
- Supports normal mode (wait for a real trigger) and auto mode (forced trigger after a timeout), so a flat input still draws a trace.

Parameters:
- DATA_W, 12, sample width.
- DEPTH, 640, samples per capture (one per screen column).
- ADDR_W, 10, buffer address width; DEPTH must be <= 2^ADDR_W.
- AUTO_TIMEOUT, 4096, accepted samples waited in WAIT_TRIG before an auto-mode forced trigger.

Ports:
- clock  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = continuous re-arm, 0 = stop after the current capture.
- sample_valid  in  1  one-cycle strobe, new ADC sample present.
- sample_data  in  DATA_W  ADC sample, unsigned.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_mode  in  1  0 = normal, 1 = auto.
- decim  in  4  decimation; accept 1 of every (decim+1) valid samples.
- frame_end  in  1  one-cycle pulse from VGA at end of visible frame.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  DATA_W  buffer write data.
- state  out  3  IDLE=0, ARM=1, WAIT_TRIG=2, CAPTURE=3, HOLD=4.
- triggered  out  1  high from trigger until the next entry into ARM (LED).
- auto_fired  out  1  high if the current capture was force-triggered.
- capture_done  out  1  one-cycle pulse when the last sample is written.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; state = IDLE.
  - Decimation counter, timeout counter and prev-sample register all 0.
- Decimation:
  - A counter counts sample_valid strobes.
  - A sample is "accepted" when the counter = 0; the counter then reloads with decim, otherwise it decrements.
  - decim = 0 accepts every valid sample.
  - The counter runs in every state except IDLE, where it is held at 0.
  - A change to decim takes effect at the next reload.
- IDLE:
  - Go to ARM when run = 1.
- ARM:
  - Clear triggered, auto_fired and the timeout counter.
  - On the first accepted sample, load prev and go to WAIT_TRIG. No trigger is evaluated on this sample.
  - run = 0 returns to IDLE.
- WAIT_TRIG (per accepted sample s):
  - Rising trigger: prev < trig_level and s >= trig_level.
  - Falling trigger: prev >= trig_level and s < trig_level.
  - All comparisons are unsigned, full width.
  - If no trigger, prev <= s.
  - In auto mode, the timeout counter increments per accepted sample. When it reaches AUTO_TIMEOUT-1 without a trigger, that sample forces a trigger and sets auto_fired.
  - On a trigger (real or forced): set triggered, write s at address 0, go to CAPTURE.
  - run = 0 returns to IDLE with no write.
  - trig_level and trig_edge are sampled live; changes apply from the next accepted sample.
- CAPTURE:
  - Each accepted sample is written at the next address.
  - Latency: wr_en/wr_addr/wr_data are registered and appear the cycle after the accepting sample_valid.
  - wr_en is high for exactly one cycle per write.
  - When address DEPTH-1 is written: pulse capture_done in the same cycle as that wr_en, then go to HOLD.
  - run = 0 does not abort; the capture always completes.
  - No wrap-around: the address never exceeds DEPTH-1.
  - wr_addr holds its last value between writes.
- HOLD:
  - No writes.
  - On frame_end: go to ARM if run = 1, otherwise IDLE.
  - A frame_end that arrives in the same cycle as the capture's final write is ignored; HOLD needs one full subsequent frame_end.
- Simultaneous events:
  - An accepted sample and a run fall in the same cycle in ARM or WAIT_TRIG: IDLE wins and no write occurs.
  - Reset asserted mid-CAPTURE abandons the capture immediately; the buffer contents are undefined.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0 and state=0; release with run=1 -> state=1 on the next clock.
- Rising trigger: decim=0, level=2048, edge=0, normal mode, ramp 0..4095 step 16, one valid every 4 clocks -> first write addr 0 data 2048; addr 639 data 2048+639*16 wrapped mod 4096; capture_done coincides with the addr-639 wr_en; state=4.
- Falling trigger with decimation: decim=3, edge=1, level=1000, descending ramp step 1 from 1200 -> triggers on the first accepted sample <1000; consecutive writes differ by 4; exactly 640 wr_en pulses.
- Auto timeout: trig_mode=1, constant input 100, level=2048 -> after 4096 accepted samples auto_fired=1 and triggered=1; 640 writes of 100. The same stimulus with trig_mode=0 -> stays in state=2 with no writes.
- HOLD/re-arm: after done, frame_end pulses with run=1 -> state=1 and triggered=0. With run=0 at frame_end -> state=0. A frame_end coincident with the final write -> remains in state=4.
- Abort/mid-op:
  - run=0 during WAIT_TRIG -> IDLE with no wr_en.
  - run=0 at addr 300 during CAPTURE -> writes continue to 639, then HOLD, then IDLE at frame_end.
  - reset=0 at addr 300 -> outputs 0 asynchronously, within the same cycle.
